// File: rtl/tt_harness_pkg.sv
// rtl/tt_harness_pkg.sv - shared state encoding and error-counter width for the IO harness
package tt_harness_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/tt_io_harness_if.sv
// rtl/tt_io_harness_if.sv - scan/apply/sense bundle of the IO harness; HARNESS_CHECK_EN adds checker signals
interface tt_io_harness_if #(
    parameter int DATA_W = 8,
    parameter int NCH    = 2
);
    import tt_harness_pkg::*;

    localparam int L = NCH * DATA_W;

    logic         shift_en;
    logic         sdi;
    logic         apply;
    logic [L-1:0] sense_in;
    logic [L-1:0] drive_out;
    logic         sdo;
    logic         busy;
    logic         done;
`ifdef HARNESS_CHECK_EN
    logic             sdi_exp;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;
`endif

    modport master (
        output shift_en, sdi, apply, sense_in,
`ifdef HARNESS_CHECK_EN
        output sdi_exp,
        input  mismatch, err_cnt,
`endif
        input  drive_out, sdo, busy, done
    );

    modport slave (
        input  shift_en, sdi, apply, sense_in,
`ifdef HARNESS_CHECK_EN
        input  sdi_exp,
        output mismatch, err_cnt,
`endif
        output drive_out, sdo, busy, done
    );

endinterface

// File: rtl/tt_harness_settle.sv
// rtl/tt_harness_settle.sv - loadable down-counter timing the gap between apply and capture
module tt_harness_settle #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam logic [7:0] SETTLE_V = 8'(SETTLE);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= SETTLE_V;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tt_io_harness.sv
// rtl/tt_io_harness.sv - scan-in stimulus, apply to DUT, capture response after a settle delay
// HARNESS_CHECK_EN adds an expected-value shadow register with sticky mismatch and saturating error count.
module tt_io_harness
    import tt_harness_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NCH    = 2,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    tt_io_harness_if.slave bus
);
    localparam int L = NCH * DATA_W;

    state_t       state, state_nxt;
    logic [L-1:0] scan;
    logic [L-1:0] drive;
    logic         done_q;
    logic         cnt_load, cnt_dec, cnt_zero;
    logic         apply_go, shift_go, capture;

    tt_harness_settle #(.SETTLE(SETTLE)) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // apply outranks shift in IDLE; both are ignored while waiting
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        apply_go  = 1'b0;
        shift_go  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.apply) begin
                    apply_go  = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = WAIT;
                end else if (bus.shift_en) begin
                    shift_go = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan   <= '0;
            drive  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= capture;
            if (apply_go) drive <= scan;
            if (shift_go)     scan <= {scan[L-2:0], bus.sdi};
            else if (capture) scan <= bus.sense_in;
        end
    end

    assign bus.drive_out = drive;
    assign bus.sdo       = scan[L-1];
    assign bus.busy      = (state == WAIT);
    assign bus.done      = done_q;

`ifdef HARNESS_CHECK_EN
    logic [L-1:0]     exp_q;
    logic             mism_q;
    logic [ERR_W-1:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q  <= '0;
            mism_q <= 1'b0;
            err_q  <= '0;
        end else begin
            if (shift_go) exp_q <= {exp_q[L-2:0], bus.sdi_exp};
            if (capture && bus.sense_in != exp_q) begin
                mism_q <= 1'b1;
                if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
            end
        end
    end

    assign bus.mismatch = mism_q;
    assign bus.err_cnt  = err_q;
`endif

endmodule
